// File: rtl/m_line_clearer.sv
// Removes every full row from a settled field in one pass and updates the column heights.
// Optional feature: define LINE_CLEARER_SCORE_EN to add a saturating 16-bit o_score output.
`ifndef COL_COUNT
`define COL_COUNT 4
`endif
`ifndef ROW_COUNT
`define ROW_COUNT 8
`endif
`ifndef PILE_COUNT_WIDTH
`define PILE_COUNT_WIDTH 4
`endif
`ifndef FIELD_SIZE
`define FIELD_SIZE (`ROW_COUNT*`COL_COUNT)
`endif
`ifndef PILE_COUNT_ARRAY_SIZE
`define PILE_COUNT_ARRAY_SIZE (`COL_COUNT*`PILE_COUNT_WIDTH)
`endif
`ifndef ROW_SIZE
`define ROW_SIZE $clog2(`ROW_COUNT)
`endif

module m_line_clearer (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic [`FIELD_SIZE-1:0]            i_field,
  input  logic [`PILE_COUNT_ARRAY_SIZE-1:0] i_pile_count_array,
  output logic                              o_ready,
  output logic                              o_done,
  output logic [`FIELD_SIZE-1:0]            o_field,
  output logic [`PILE_COUNT_ARRAY_SIZE-1:0] o_pile_count_array,
`ifdef LINE_CLEARER_SCORE_EN
  output logic [15:0]                       o_score,
`endif
  output logic [`ROW_SIZE:0]                o_cleared_count
);

  localparam int unsigned Cols = `COL_COUNT;
  localparam int unsigned Rows = `ROW_COUNT;
  localparam int unsigned PcW  = `PILE_COUNT_WIDTH;
  localparam int unsigned RowW = `ROW_SIZE;
  localparam logic [RowW-1:0] LastRow = RowW'(Rows - 1);

  typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

  state_e                              r_state;
  logic                                r_ready;
  logic                                r_done;
  logic [`FIELD_SIZE-1:0]              r_field;
  logic [`PILE_COUNT_ARRAY_SIZE-1:0]   r_pc;
  logic [RowW-1:0]                     r_row;
  logic [RowW:0]                       r_cnt;

  logic                                w_row_full;
  logic [`FIELD_SIZE-1:0]              w_above;
  logic [`FIELD_SIZE-1:0]              w_shift_field;
  logic [`PILE_COUNT_ARRAY_SIZE-1:0]   w_dec_pc;

  always_comb begin
    w_row_full = &r_field[int'(r_row)*Cols +: Cols];
  end

  // Rows below the current index stay; the rest take the row above (top fills with 0).
  always_comb begin
    w_above       = r_field >> Cols;
    w_shift_field = '0;
    for (int i = 0; i < int'(Rows); i++) begin
      if (i < int'(r_row)) w_shift_field[i*Cols +: Cols] = r_field[i*Cols +: Cols];
      else                 w_shift_field[i*Cols +: Cols] = w_above[i*Cols +: Cols];
    end
  end

  always_comb begin
    w_dec_pc = '0;
    for (int c = 0; c < int'(Cols); c++) begin
      if (r_pc[c*PcW +: PcW] == '0) w_dec_pc[c*PcW +: PcW] = '0;
      else                          w_dec_pc[c*PcW +: PcW] = r_pc[c*PcW +: PcW] - 1'b1;
    end
  end

`ifdef LINE_CLEARER_SCORE_EN
  logic [15:0] r_score;
  logic [16:0] w_score_sum;
  always_comb begin
    w_score_sum = {1'b0, r_score} + 17'(r_cnt * r_cnt);
  end
  assign o_score = r_score;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_field <= '0;
      r_pc    <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
`ifdef LINE_CLEARER_SCORE_EN
      r_score <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_field <= i_field;
            r_pc    <= i_pile_count_array;
            r_row   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= StScan;
          end
        end
        StScan: begin
          if (w_row_full) begin
            r_state <= StShift;
          end else if (r_row == LastRow) begin
            r_state <= StDone;
            r_done  <= 1'b1;
`ifdef LINE_CLEARER_SCORE_EN
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
`endif
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        StShift: begin
          r_field <= w_shift_field;
          r_pc    <= w_dec_pc;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= StScan;
        end
        StDone: begin
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ready            = r_ready;
  assign o_done             = r_done;
  assign o_field            = r_field;
  assign o_pile_count_array = r_pc;
  assign o_cleared_count    = r_cnt;

endmodule
